// File: rtl/counter_ctrl_if.sv
// Requester-side and counter-side signals of counter_ctrl; slave = controller, master = environment.
// abort/aborted exist only when COUNTER_CTRL_ABORT_EN is defined.
interface counter_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_start;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [DATA_WIDTH-1:0]         result;
  logic                          busy;
  logic                          cnt_load;
  logic                          cnt_enable;
  logic [DATA_WIDTH-1:0]         cnt_data;
  logic [DATA_WIDTH-1:0]         cnt_count;
`ifdef COUNTER_CTRL_ABORT_EN
  logic                          abort;
  logic                          aborted;

  modport slave (
    input  req, req_start, req_len, cnt_count, abort,
    output gnt, done, result, busy, cnt_load, cnt_enable, cnt_data, aborted
  );
  modport master (
    output req, req_start, req_len, cnt_count, abort,
    input  gnt, done, result, busy, cnt_load, cnt_enable, cnt_data, aborted
  );
`else
  modport slave (
    input  req, req_start, req_len, cnt_count,
    output gnt, done, result, busy, cnt_load, cnt_enable, cnt_data
  );
  modport master (
    output req, req_start, req_len, cnt_count,
    input  gnt, done, result, busy, cnt_load, cnt_enable, cnt_data
  );
`endif
endinterface

// File: rtl/counter_ctrl.sv
// Round-robin job sequencer sharing one loadable up-counter; optional abort via COUNTER_CTRL_ABORT_EN.
// Grant 1 cycle after req, done/result len+3 cycles after req; req is a level held until done.
module counter_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int LEN_WIDTH  = 8
) (
  input  logic          clk,
  input  logic          rstN,
  counter_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t                 state_q;
  logic [NUM_REQ-1:0]     gnt_q;
  logic [NUM_REQ-1:0]     done_q;
  logic [DATA_WIDTH-1:0]  result_q;
  logic [DATA_WIDTH-1:0]  start_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   rem_q;
  logic [IDX_W-1:0]       last_q;

  logic                   pick_vld_d;
  logic [IDX_W-1:0]       pick_idx_d;
  logic [DATA_WIDTH-1:0]  pick_start_d;
  logic [LEN_WIDTH-1:0]   pick_len_d;
  logic                   abort_req;

`ifdef COUNTER_CTRL_ABORT_EN
  logic abt_q;
  logic aborted_q;
  assign abort_req   = bus.abort;
  assign bus.aborted = aborted_q;
`else
  assign abort_req = 1'b0;
`endif

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
    return IDX_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // Scan downwards so the candidate closest after the last owner wins.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[rr_idx(last_q, k)]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = rr_idx(last_q, k);
      end
    end
  end

  always_comb begin
    pick_start_d = '0;
    pick_len_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx_d == IDX_W'(i)) begin
        pick_start_d = bus.req_start[i*DATA_WIDTH +: DATA_WIDTH];
        pick_len_d   = bus.req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      result_q  <= '0;
      start_q   <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
`ifdef COUNTER_CTRL_ABORT_EN
      abt_q     <= 1'b0;
      aborted_q <= 1'b0;
`endif
    end else begin
      done_q    <= '0;
`ifdef COUNTER_CTRL_ABORT_EN
      aborted_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            gnt_q   <= NUM_REQ'(1) << pick_idx_d;
            start_q <= pick_start_d;
            len_q   <= pick_len_d;
            last_q  <= pick_idx_d;
            state_q <= LOAD;
`ifdef COUNTER_CTRL_ABORT_EN
            abt_q   <= 1'b0;
`endif
          end
        end
        LOAD: begin
          rem_q   <= len_q;
          state_q <= (len_q == '0 || abort_req) ? DONE : RUN;
`ifdef COUNTER_CTRL_ABORT_EN
          abt_q   <= abort_req;
`endif
        end
        RUN: begin
          rem_q <= rem_q - LEN_WIDTH'(1);
          if (rem_q == LEN_WIDTH'(1) || abort_req) begin
            state_q <= DONE;
          end
`ifdef COUNTER_CTRL_ABORT_EN
          abt_q <= abort_req;
`endif
        end
        DONE: begin
          result_q  <= bus.cnt_count;
          done_q    <= gnt_q;
          gnt_q     <= '0;
          state_q   <= IDLE;
`ifdef COUNTER_CTRL_ABORT_EN
          aborted_q <= abt_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.cnt_load   = (state_q == LOAD);
  assign bus.cnt_enable = (state_q == LOAD) || (state_q == RUN);
  assign bus.cnt_data   = (state_q == LOAD) ? start_q : '0;
endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencer and round-robin arbiter for one loadable up-counter (interface: load, enable, Data_in, count).
- Shares the counter between NUM_REQ requesters. Each job is "load start value, count up len steps, return final count".
- Sits between requester blocks and the counter instance; it is the only driver of the counter's load, enable and Data_in.

Parameters:
DATA_WIDTH, 8, width of counter value, start value and result
NUM_REQ, 4, number of requesters (>=2)
LEN_WIDTH, 8, width of per-job step count

Ports:
clk  in  1  single clock, rising edge
rstN  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester job request, level
req_start  in  NUM_REQ*DATA_WIDTH  packed start values; slice i = requester i
req_len  in  NUM_REQ*LEN_WIDTH  packed step counts; slice i = requester i
gnt  out  NUM_REQ  one-hot owner of the current job; 0 when idle
done  out  NUM_REQ  one-cycle completion pulse to the owner
result  out  DATA_WIDTH  final count of the last completed job
busy  out  1  high when state != IDLE
cnt_load  out  1  to counter load
cnt_enable  out  1  to counter enable
cnt_data  out  DATA_WIDTH  to counter Data_in
cnt_count  in  DATA_WIDTH  from counter count

Behaviour:
- Clock and reset: one clock, clk. Reset rstN is asynchronous, active-low.
- Reset values: all outputs 0. State = IDLE. Round-robin pointer set so req[0] has highest priority. Latched start/len = 0. A reset mid-job drops the job with no done pulse.
- All outputs are registered. cnt_* are decoded from registered state and latched operands.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If req != 0, pick the first asserted req scanning from (last owner + 1) mod NUM_REQ.
  - Latch that requester's start and len, set gnt one-hot, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD (1 cycle):
  - cnt_load=1, cnt_enable=1, cnt_data=latched start.
  - If len==0, go to DONE; else load remaining=len and go to RUN.
- RUN:
  - cnt_load=0, cnt_enable=1, remaining decrements each cycle.
  - On the cycle with remaining==1, go to DONE (exactly len enable cycles in RUN).
- DONE (1 cycle):
  - cnt_enable=0; the counter holds start+len.
  - At the exiting edge: result<=cnt_count, done<=gnt, gnt<=0, last owner<=current owner, go to IDLE.
- Latency: req sampled in IDLE at cycle 0:
  - gnt high cycles 1..len+2
  - done and new result in cycle len+3
  - next arbitration in that same cycle
  - back-to-back jobs every len+3 cycles.
- Arithmetic: result = (start+len) mod 2^DATA_WIDTH. Wrap is native counter wrap. No overflow flag.
- Commitment: operands are captured only at grant. req or operand changes after grant are ignored and the job always completes.
- Handshake: a requester deasserts req in its done cycle. If req is still high in a later IDLE cycle, it is a new job, served after the other pending requesters (round-robin fairness).
- Single requester: served repeatedly with no starvation penalty.

Optional Feature:
- Macro: COUNTER_CTRL_ABORT_EN.
- Enabled: adds input abort (1 bit).
  - abort=1 in LOAD or RUN forces DONE on the next cycle.
  - result captures cnt_count as is (partial count); done pulses normally.
  - Adds output aborted (1 bit), pulsed together with done; reset 0.
  - abort is ignored in IDLE and DONE.
- Disabled: no abort/aborted ports; jobs always run to completion.

Test Plan:
1. req=4'b0001, start0=0x10, len0=5 -> gnt=0001 cycles 1-7, cnt_load=1 only cycle 1, done=0001 in cycle 8, result=0x15, busy low in cycle 8.
2. start0=0xFE, len0=3 -> result=0x01 (wrap), done after exactly 6 cycles.
3. start2=0x42, len2=0 on req[2] -> cnt_enable high only in the LOAD cycle, done=0100 in cycle 3, result=0x42.
4. req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0, a new gnt every 4 cycles, each done matches its owner.
5. rstN low mid-RUN (job start 0x20, len 10) -> all outputs 0 immediately with no done. After release with req[1] high, req[1] is granted from IDLE.
6. With COUNTER_CTRL_ABORT_EN: start 0x00, len 20, abort at RUN cycle 4 -> done and aborted pulse together, result equal to the cnt_count sampled in DONE (0x04).
